// File: rtl/mult_seq_if.sv
// mult_seq_if: operand/result handshake bundle for the sequential multiplier.
// The is_signed signal is present only when MULT_SIGNED_EN is defined.
interface mult_seq_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
`ifdef MULT_SIGNED_EN
  logic             is_signed;
`endif
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;

  // Requester side (pipeline issuing the multiply)
  modport master (
    output in_valid, x, y,
`ifdef MULT_SIGNED_EN
    output is_signed,
`endif
    output flush, out_ready,
    input  in_ready, out_valid, w_lo, w_hi
  );

  // Multiplier side
  modport slave (
    input  in_valid, x, y,
`ifdef MULT_SIGNED_EN
    input  is_signed,
`endif
    input  flush, out_ready,
    output in_ready, out_valid, w_lo, w_hi
  );

endinterface

// File: rtl/mult_seq.sv
// mult_seq: iterative shift-add multiplier, one partial product per cycle,
// returning the full 2*WIDTH-bit product as w_hi:w_lo.
// Optional feature macro: MULT_SIGNED_EN (adds is_signed, two's-complement mode).
module mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mult_seq_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] w_lo_q, w_lo_d;
  logic [WIDTH-1:0] w_hi_q, w_hi_d;
`ifdef MULT_SIGNED_EN
  logic             neg_q, neg_d;
`endif

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    res;
  logic [WIDTH-1:0] mag_x;
  logic [WIDTH-1:0] mag_y;

  // Single adder: accumulate M into A when the current multiplier bit is set
  always_comb begin
    addend = q_q[0] ? m_q : '0;
    sum    = {1'b0, a_q} + {1'b0, addend};
  end

  // Operand magnitudes at accept and the sign-corrected final product
  always_comb begin
    prod = {a_q, q_q};
`ifdef MULT_SIGNED_EN
    mag_x = (bus.is_signed && bus.x[WIDTH-1]) ? (~bus.x + WIDTH'(1)) : bus.x;
    mag_y = (bus.is_signed && bus.y[WIDTH-1]) ? (~bus.y + WIDTH'(1)) : bus.y;
    res   = neg_q ? (~prod + PW'(1)) : prod;
`else
    mag_x = bus.x;
    mag_y = bus.y;
    res   = prod;
`endif
  end

  // Next-state and next-output logic; flush has priority in every state
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    w_lo_d      = w_lo_q;
    w_hi_d      = w_hi_q;
`ifdef MULT_SIGNED_EN
    neg_d       = neg_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!bus.flush && bus.in_valid) begin
          m_d        = mag_x;
          q_d        = mag_y;
          a_d        = '0;
          cnt_d      = '0;
`ifdef MULT_SIGNED_EN
          neg_d      = bus.is_signed && (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
`endif
          state_d    = S_RUN;
          in_ready_d = 1'b0;
        end
      end

      S_RUN: begin
        if (bus.flush) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end else begin
          a_d   = sum[WIDTH:1];
          q_d   = {sum[0], q_q[WIDTH-1:1]};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (bus.flush) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end else if (!out_valid_q) begin
          // First DONE cycle: register the sign-corrected product
          w_lo_d      = res[WIDTH-1:0];
          w_hi_d      = res[PW-1:WIDTH];
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      w_lo_q      <= '0;
      w_hi_q      <= '0;
`ifdef MULT_SIGNED_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      w_lo_q      <= w_lo_d;
      w_hi_q      <= w_hi_d;
`ifdef MULT_SIGNED_EN
      neg_q       <= neg_d;
`endif
    end
  end

  // Registered outputs onto the bus
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.w_lo      = w_lo_q;
  assign bus.w_hi      = w_hi_q;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: self-checking bench for mult_seq against a plain-arithmetic
// product model. Signed cases run only when MULT_SIGNED_EN is defined.
module tb_mult_seq;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus();

  mult_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: full-width product of sign- or zero-extended operands
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input bit s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    logic [2*W-1:0] p;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p  = ea * eb;
    return p;
  endfunction

  task automatic set_sign(input bit s);
`ifdef MULT_SIGNED_EN
    bus.is_signed = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  // Full transaction: accept, latency check, optional stall, handshake
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int stall, input string tag);
    logic [2*W-1:0] exp;
    bit sg;
    sg = s;
`ifndef MULT_SIGNED_EN
    sg = 1'b0;
`endif
    exp = ref_mul(a, b, sg);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: in_ready=%b want 1", tag, bus.in_ready);
    end
    bus.x = a; bus.y = b; set_sign(sg); bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.x = $urandom; bus.y = $urandom; set_sign(1'b0);
    for (int k = 0; k <= int'(W); k++) begin
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s latency edge %0d: valid,ready=%b%b want 00",
                 tag, k, bus.out_valid, bus.in_ready);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || {bus.w_hi, bus.w_lo} !== exp) begin
      n_fail++;
      $display("FAIL %s result: valid=%b hi=%h lo=%h want valid=1 hi=%h lo=%h",
               tag, bus.out_valid, bus.w_hi, bus.w_lo, exp[2*W-1:W], exp[W-1:0]);
    end
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, bus.w_hi, bus.w_lo} !== {2'b10, exp}) begin
        n_fail++;
        $display("FAIL %s stall %0d: valid=%b ready=%b hi=%h lo=%h want 1 0 %h %h",
                 tag, c, bus.out_valid, bus.in_ready, bus.w_hi, bus.w_lo,
                 exp[2*W-1:W], exp[W-1:0]);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s handshake: valid,ready=%b%b want 01", tag, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.w_lo, bus.w_hi} !== {2'b10, {(2*W){1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b valid=%b lo=%h hi=%h want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.w_lo, bus.w_hi);
    end
  endtask

  task automatic test_basic();
    run_op(32'd3, 32'd5, 1'b0, 0, "basic_3x5");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "full_range");
    run_op(32'd0, 32'hDEAD_BEEF, 1'b0, 0, "zero_x");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1, "msb_unsigned");
  endtask

  task automatic test_signed();
`ifdef MULT_SIGNED_EN
    run_op(32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 0, "signed_m1x7");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "signed_min_sq");
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, "signed_min_x1");
    for (int i = 0; i < 8; i++) begin
      run_op($urandom, $urandom, 1'b1, int'($urandom_range(0, 2)), "signed_rand");
    end
`endif
  endtask

  task automatic test_backpressure();
    run_op(32'h1234_5678, 32'h0000_0010, 1'b0, 10, "backpressure");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      run_op($urandom, $urandom, bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), "b2b_rand");
    end
  endtask

  task automatic test_flush();
    bit seen;
    int budget;
    // Abort mid-RUN
    bus.x = $urandom; bus.y = $urandom; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_run: valid,ready=%b%b want 01", bus.out_valid, bus.in_ready);
    end
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL flush_run_novalid: out_valid seen=1 want 0");
    end
    // flush beats in_valid in IDLE
    bus.x = 32'd9; bus.y = 32'd9; bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_accept: in_ready=%b want 1", bus.in_ready);
    end
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_fail++;
      $display("FAIL flush_idle_novalid: out_valid seen=1 want 0");
    end
    run_op(32'd2, 32'd3, 1'b0, 0, "after_flush_2x3");
    // Discard a DONE product even with out_ready high
    bus.x = $urandom; bus.y = $urandom; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    budget = 0;
    while (bus.out_valid !== 1'b1 && budget < 4 * int'(W)) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_done_wait: out_valid=%b want 1 within budget", bus.out_valid);
    end
    bus.flush = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_done: valid,ready=%b%b want 01", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_async_reset();
    bus.x = $urandom; bus.y = $urandom; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, bus.w_lo, bus.w_hi} !== {2'b10, {(2*W){1'b0}}}) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b valid=%b lo=%h hi=%h want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.w_lo, bus.w_hi);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op($urandom, $urandom, 1'b0, 0, "after_reset");
    run_op(32'hFFFF_0001, 32'h0001_FFFF, 1'b1, 0, "after_reset_2");
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    set_sign(1'b0);
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
